// File: rtl/vdp_timing_pkg.sv
// Display timing constants and the line fetch state type. The timing
// generator and the line fetch scheduler both import this package.
package vdp_timing_pkg;

   localparam int HA_END = 1279;
   localparam int LINE   = 1359;
   localparam int VA_END = 719;
   localparam int SCREEN = 740;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DATA = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/line_fetch_sched.sv
// Scanline prefetch: during each line, burst-fetches the next active line
// from the framebuffer into the idle half of a ping-pong line buffer.
//
// state | meaning
// IDLE  | waiting for the end-of-active trigger of a line
// REQ   | burst request held on mem_req/mem_addr until mem_ack
// DATA  | collecting BURST beats into the line buffer
module line_fetch_sched
   import vdp_timing_pkg::*;
#(
   parameter int WORDS  = 80,
   parameter int BURST  = 16,
   parameter int STRIDE = 80,
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32
) (
   input  logic                      clk_pix,
   input  logic                      rst_pix,
   input  logic [10:0]               sx,
   input  logic [10:0]               sy,
   input  logic                      enable,
   input  logic [ADDR_W-1:0]         fb_base,
   output logic                      mem_req,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic                      mem_ack,
   input  logic                      mem_rvalid,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      lb_we,
   output logic [$clog2(WORDS):0]    lb_waddr,
   output logic [DATA_W-1:0]         lb_wdata,
   output logic                      busy,
   output logic                      underrun,
   input  logic                      underrun_clr
);

   localparam int NB = WORDS / BURST;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int WW = $clog2(WORDS);

   fetch_state_t      state;
   logic [ADDR_W-1:0] base_q;
   logic [10:0]       tgt;
   logic [BW-1:0]     b;
   logic [CW-1:0]     beat;
   logic [WW-1:0]     w;

   logic [10:0]       t;
   logic              trigger;
   logic              last_beat;
   logic              last_burst;

   assign t          = (sy == 11'(SCREEN)) ? 11'd0 : sy + 11'd1;
   assign trigger    = (sx == 11'(HA_END + 1)) && enable && (t <= 11'(VA_END)) && (state == IDLE);
   assign last_beat  = (beat == CW'(BURST - 1));
   assign last_burst = (b == BW'(NB - 1));

   // Address arithmetic is deliberately ADDR_W wide so it wraps silently.
   function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [10:0]       line,
                                                    input logic [BW-1:0]     bi);
      return base + ADDR_W'(line) * ADDR_W'(STRIDE) + ADDR_W'(bi) * ADDR_W'(BURST);
   endfunction

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         lb_we    <= 1'b0;
         lb_waddr <= '0;
         lb_wdata <= '0;
         busy     <= 1'b0;
         underrun <= 1'b0;
         base_q   <= '0;
         tgt      <= '0;
         b        <= '0;
         beat     <= '0;
         w        <= '0;
      end else begin
         lb_we <= 1'b0;

         // Base capture precedes the line-0 trigger later on the same line.
         if (sx == 11'd0 && sy == 11'(SCREEN))
            base_q <= fb_base;

         if (sx == 11'd0 && sy <= 11'(VA_END) && busy && tgt == sy)
            underrun <= 1'b1;
         else if (underrun_clr)
            underrun <= 1'b0;

         case (state)
            IDLE: begin
               if (trigger) begin
                  tgt      <= t;
                  b        <= '0;
                  w        <= '0;
                  state    <= REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= burst_addr(base_q, t, '0);
                  busy     <= 1'b1;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  beat    <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (mem_rvalid) begin
                  lb_we    <= 1'b1;
                  lb_waddr <= {tgt[0], w};
                  lb_wdata <= mem_rdata;
                  w        <= w + WW'(1);
                  beat     <= beat + CW'(1);
                  if (last_beat) begin
                     if (last_burst) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        b        <= b + BW'(1);
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= burst_addr(base_q, tgt, b + BW'(1));
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
